// File: rtl/riscv_pkg.sv
// Shared RV32 constants: load funct3 encodings and byte-lane width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_pkg;
    localparam int BYTE_W = 8;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
endpackage

// File: rtl/load_extend.sv
// Formats a 32-bit word into an RV32 load result (byte/half select, sign/zero extend).
// Latency: combinational.
// Backpressure: none.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  load_type,
    output logic [31:0] result
);
    logic [BYTE_W-1:0]   byte_sel;
    logic [2*BYTE_W-1:0] half_sel;

    always_comb begin
        byte_sel = word_in[byte_off*BYTE_W +: BYTE_W];
        // Halfword alignment comes from bit 1 only; bit 0 is deliberately dropped.
        half_sel = byte_off[1] ? word_in[31:16] : word_in[15:0];
        case (load_type)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   result = {24'd0, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_HU:   result = {16'd0, half_sel};
            LD_W:    result = word_in;
            default: result = word_in;
        endcase
    end
endmodule

// File: rtl/data_ram.sv
// Byte-addressable data RAM: byte-enabled synchronous writes, combinational formatted reads.
// Latency: writes land on the rising edge; reads are zero-latency.
// Backpressure: none, always ready.
module data_ram
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [3:0]            write_byte_enable,
    input  logic [2:0]            load_type,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data_out
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);

    logic [BYTE_W-1:0] mem_q [MEM_SIZE];
    logic [BYTE_W-1:0] mem_d [MEM_SIZE];

    logic                  in_range;
    logic [AW-1:0]         base;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ext_word;

    // Word base is below the limit exactly when addr is, since MEM_SIZE is a multiple of 4.
    assign in_range = addr < MEM_LIMIT;
    assign base     = {addr[AW-1:2], 2'b00};

    always_comb begin
        mem_d = mem_q;
        if (wr_en && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (write_byte_enable[i]) begin
                    mem_d[base | AW'(i)] = wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word[i*BYTE_W +: BYTE_W] = mem_q[base | AW'(i)];
        end
    end

    load_extend u_load_extend (
        .word_in   (rd_word),
        .byte_off  (addr[1:0]),
        .load_type (load_type),
        .result    (ext_word)
    );

    always_comb begin
        rd_data_out = '0;
        if (rd_en && in_range && !rst) begin
            rd_data_out = ext_word;
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: directed plan steps then random traffic against a byte-array model.
module tb_data_ram;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  write_byte_enable;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] model [64];

    data_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .rd_en             (rd_en),
        .write_byte_enable (write_byte_enable),
        .load_type         (load_type),
        .addr              (addr),
        .wr_data           (wr_data),
        .rd_data_out       (rd_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp);
        total++;
        assert (rd_data_out === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, rd_data_out, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] lt, input bit en);
        int b;
        int hb;
        logic [7:0]  by;
        logic [15:0] h;
        logic [31:0] w;
        if (!en || a >= 64) return 32'd0;
        b  = a - (a % 4);
        hb = b + 2 * ((a % 4) / 2);
        w  = {model[b+3], model[b+2], model[b+1], model[b]};
        by = model[a];
        h  = {model[hb+1], model[hb]};
        case (lt)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'd0, by};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] be);
        int b;
        if (a >= 64) return;
        b = a - (a % 4);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model[b+i] = d[8*i +: 8];
        end
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr = 32'(a); wr_data = d; write_byte_enable = be; wr_en = 1'b1; rd_en = 1'b0;
        @(posedge clk);
        model_write(a, d, be);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic set_read(input int a, input logic [2:0] lt, input bit en);
        @(negedge clk);
        addr = 32'(a); load_type = lt; rd_en = en; wr_en = 1'b0;
        #1;
    endtask

    task automatic read_check(input string tag, input int a, input logic [2:0] lt,
                              input bit en, input logic [31:0] exp);
        set_read(a, lt, en);
        check(tag, exp);
        check({tag, "_model"}, ref_load(a, lt, en));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b1; write_byte_enable = 4'h0;
        load_type = 3'b010; addr = 32'd0; wr_data = 32'd0;
        clear_model();
        #12;
        check("reset_held_out", 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset pulse between edges wipes a stored word.
        do_write(0, 32'hDEADBEEF, 4'hF);
        read_check("pre_reset_lw0", 0, 3'b010, 1, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1 check("rst_held_lw0", 32'd0);
        #1 rst = 1'b0;
        clear_model();
        #1 check("post_reset_lw0", 32'd0);

        // Write pending at the edge is lost when reset covers it.
        do_write(20, 32'h55667788, 4'hF);
        @(negedge clk);
        addr = 32'd20; wr_data = 32'hCAFEF00D; write_byte_enable = 4'hF; wr_en = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        wr_en = 1'b0;
        clear_model();
        read_check("rst_kills_write", 20, 3'b010, 1, 32'd0);

        do_write(8, 32'h800000FF, 4'hF);
        read_check("lw8",   8,  3'b010, 1, 32'h800000FF);
        read_check("lb8",   8,  3'b000, 1, 32'hFFFFFFFF);
        read_check("lbu8",  8,  3'b100, 1, 32'h000000FF);
        read_check("lb11",  11, 3'b000, 1, 32'hFFFFFF80);

        do_write(4, 32'h11223344, 4'hF);
        do_write(4, 32'hAA000000, 4'b1000);
        read_check("merge_lw4", 4, 3'b010, 1, 32'hAA223344);
        do_write(4, 32'hFFFFFFFF, 4'b0000);
        read_check("mask0_lw4", 4, 3'b010, 1, 32'hAA223344);

        do_write(12, 32'h00008001, 4'hF);
        read_check("lh12",  12, 3'b001, 1, 32'hFFFF8001);
        read_check("lhu12", 12, 3'b101, 1, 32'h00008001);
        read_check("lh14",  14, 3'b001, 1, 32'h00000000);
        read_check("lh13",  13, 3'b001, 1, 32'hFFFF8001);
        read_check("rsv12", 12, 3'b111, 1, 32'h00008001);

        read_check("rd_en0", 8, 3'b010, 0, 32'd0);
        do_write(0, 32'h0BADF00D, 4'hF);
        do_write(64, 32'h12345678, 4'hF);
        read_check("oob_lw64", 64, 3'b010, 1, 32'd0);
        read_check("lw0_after_oob", 0, 3'b010, 1, 32'h0BADF00D);

        // Same-word read and write: old data before the edge, new after, no bypass.
        @(negedge clk);
        addr = 32'd16; wr_data = 32'h12345678; write_byte_enable = 4'hF;
        load_type = 3'b010; wr_en = 1'b1; rd_en = 1'b1;
        #1 check("rw_before_edge", 32'd0);
        @(posedge clk);
        model_write(16, 32'h12345678, 4'hF);
        #1 check("rw_after_edge", 32'h12345678);
        wr_en = 1'b0;

        for (int n = 0; n < 300; n++) begin
            int a;
            a = int'($urandom_range(0, 71));
            if ($urandom_range(0, 2) == 0) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                set_read(a, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 7) != 0));
                check("rand_read", ref_load(a, load_type, rd_en));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Byte-addressable data RAM for the single-issue RV32 core. It sits behind the SoC address decoder, which passes in an offset-relative address (CPU address minus the data-memory base).
- Writes are synchronous with per-lane byte enables.
- Reads are combinational and return RISC-V load-formatted data (LB/LH/LW/LBU/LHU) to the CPU read-data mux.

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported.
- ADDR_WIDTH, 32, width of the addr port.
- MEM_SIZE, 64, storage size in bytes; must be a multiple of 4.

Ports:
- clk  input  1  clock; all writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe, already qualified by the address decode.
- rd_en  input  1  read strobe, already qualified by the address decode.
- write_byte_enable  input  4  lane mask; bit i enables byte lane i of the addressed word.
- load_type  input  3  RISC-V load funct3.
- addr  input  ADDR_WIDTH  byte offset into the RAM.
- wr_data  input  DATA_WIDTH  store data, already lane-aligned by the CPU.
- rd_data_out  output  DATA_WIDTH  formatted load result (combinational).

Behaviour:
- Storage: MEM_SIZE bytes.
  - Word index = addr[ADDR_WIDTH-1:2].
  - Lane i of the word is the byte at index*4+i.
  - Little-endian layout.
- Reset:
  - rst=1 asynchronously clears every byte to 0x00.
  - While rst is held, writes are ignored and rd_data_out = 0.
- Write:
  - On posedge clk with wr_en=1 and rst=0, each lane i with write_byte_enable[i]=1 takes wr_data[8i+7:8i].
  - Other lanes are unchanged. A mask of 0000 writes nothing.
- Write range checks:
  - A write with addr >= MEM_SIZE is ignored.
  - The range check is on the word base (addr & ~3).
- Read gating:
  - rd_data_out is purely combinational from addr, load_type, rd_en and the stored bytes; there is zero latency.
  - rd_en=0 gives rd_data_out=0.
  - addr >= MEM_SIZE gives 0.
- Load formatting (W = addressed word):
  - 000 LB: byte at lane addr[1:0], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at lanes {addr[1],0}, sign-extended; addr[0] is ignored (no misaligned traps here).
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: W; addr[1:0] ignored.
  - 011/110/111 (reserved): W unmodified.
- Simultaneous rd_en and wr_en to the same word in one cycle:
  - Before the edge, the read returns the old contents.
  - After the edge, it returns the new contents; there is no bypass.
- Assertion of rst mid-cycle, including during a write, clears the array immediately; the pending write is lost.

Decomposition:
- Shared package riscv_pkg holds the load-type constants LD_B=3'b000, LD_H=3'b001, LD_W=3'b010, LD_BU=3'b100, LD_HU=3'b101, and the byte-lane width constant.
- One sub-module, load_extend, is natural. It is combinational and maps (word, byte offset, load_type) to the 32-bit formatted result; the core's writeback path reuses it.

Test Plan:
- Reset: write 0xDEADBEEF at addr 0 with mask 1111, then pulse rst between clock edges. An LW at 0 with rd_en=1 returns 0x00000000.
- Word store/load: SW 0x8000_00FF at addr 8 with mask 1111.
  - LW at 8 -> 0x800000FF.
  - LB at 8 -> 0xFFFFFFFF.
  - LBU at 8 -> 0x000000FF.
  - LB at 11 -> 0xFFFFFF80.
- Byte-enable merge: SW 0x11223344 at 4, then write wr_data 0xAA000000 with mask 1000. LW at 4 -> 0xAA223344.
- Halfword: SW 0x0000_8001 at 12.
  - LH at 12 -> 0xFFFF8001.
  - LHU at 12 -> 0x00008001.
  - LH at 14 -> 0x00000000.
  - LH at 13 -> 0xFFFF8001 (addr[0] ignored).
- Gating and range:
  - rd_en=0 at a nonzero location -> 0.
  - A write at addr 64 (MEM_SIZE=64) is ignored and an LW at 64 returns 0.
  - An LW at 0 afterwards is unchanged.
- Same-cycle read/write: addr 16 holds 0x0. With wr_en and rd_en both set and wr_data 0x12345678, rd_data_out reads 0x0 before the edge and 0x12345678 after it.
